// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core with load-use hazard
// detection, one-cycle bubble insertion, flush squash and a stall-cycle counter.
module id_ex_hazard_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              ID_VALID,
    input  logic [6:0]        ID_OP,
    input  logic [REG_AW-1:0] ID_RS1,
    input  logic [REG_AW-1:0] ID_RS2,
    input  logic [REG_AW-1:0] ID_RD,
    input  logic              ID_RS1_used,
    input  logic              ID_RS2_used,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic [XLEN-1:0]   ID_RD1,
    input  logic [XLEN-1:0]   ID_RD2,
    input  logic [XLEN-1:0]   ID_IMM,
    input  logic [XLEN-1:0]   ID_PC,
    input  logic              FLUSH,
    input  logic              HOLD,
    output logic              ID_EX_VALID,
    output logic [6:0]        ID_EX_OP,
    output logic [REG_AW-1:0] ID_EX_RS1,
    output logic [REG_AW-1:0] ID_EX_RS2,
    output logic [REG_AW-1:0] ID_EX_RD,
    output logic              ID_EX_RS1_used,
    output logic              ID_EX_RS2_used,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic [XLEN-1:0]   ID_EX_RD1,
    output logic [XLEN-1:0]   ID_EX_RD2,
    output logic [XLEN-1:0]   ID_EX_IMM,
    output logic [XLEN-1:0]   ID_EX_PC,
    output logic              STALL,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic              dbg_state
);

    localparam logic [6:0] NOP_OP = 7'b0010011;

    typedef enum logic {
        RUN       = 1'b0,
        LU_BUBBLE = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   hz;
    logic   rs1_match;
    logic   rs2_match;

    // Handshake: ID_VALID marks a real instruction in IF/ID; it advances into
    // ID_EX on an edge where HOLD, FLUSH and STALL are all low. STALL=1 tells
    // the front end to keep PC and IF/ID unchanged for this cycle.
    always_comb begin
        rs1_match = ID_RS1_used & (ID_RS1 == ID_EX_RD);
        rs2_match = ID_RS2_used & (ID_RS2 == ID_EX_RD);
        hz        = ID_VALID & ID_EX_VALID & ID_EX_MemRead &
                    (ID_EX_RD != '0) & (rs1_match | rs2_match);
    end

    assign STALL     = RSTn & hz & ~FLUSH & ~HOLD;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:       if (STALL) state_d = LU_BUBBLE;
            LU_BUBBLE: if (!HOLD) state_d = RUN;
            default:   state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ID_EX_VALID    <= 1'b0;
            ID_EX_OP       <= '0;
            ID_EX_RS1      <= '0;
            ID_EX_RS2      <= '0;
            ID_EX_RD       <= '0;
            ID_EX_RS1_used <= 1'b0;
            ID_EX_RS2_used <= 1'b0;
            ID_EX_RegWrite <= 1'b0;
            ID_EX_MemRead  <= 1'b0;
            ID_EX_MemWrite <= 1'b0;
            ID_EX_RD1      <= '0;
            ID_EX_RD2      <= '0;
            ID_EX_IMM      <= '0;
            ID_EX_PC       <= '0;
        end else if (!HOLD) begin
            if (FLUSH || STALL) begin
                ID_EX_VALID    <= 1'b0;
                ID_EX_OP       <= NOP_OP;
                ID_EX_RS1      <= '0;
                ID_EX_RS2      <= '0;
                ID_EX_RD       <= '0;
                ID_EX_RS1_used <= 1'b0;
                ID_EX_RS2_used <= 1'b0;
                ID_EX_RegWrite <= 1'b0;
                ID_EX_MemRead  <= 1'b0;
                ID_EX_MemWrite <= 1'b0;
                ID_EX_RD1      <= '0;
                ID_EX_RD2      <= '0;
                ID_EX_IMM      <= '0;
                ID_EX_PC       <= '0;
            end else begin
                // x0 is never marked as written so it can't be a forwarding source
                ID_EX_VALID    <= ID_VALID;
                ID_EX_OP       <= ID_OP;
                ID_EX_RS1      <= ID_RS1;
                ID_EX_RS2      <= ID_RS2;
                ID_EX_RD       <= ID_RD;
                ID_EX_RS1_used <= ID_RS1_used;
                ID_EX_RS2_used <= ID_RS2_used;
                ID_EX_RegWrite <= ID_RegWrite & ID_VALID & (ID_RD != '0);
                ID_EX_MemRead  <= ID_MemRead & ID_VALID;
                ID_EX_MemWrite <= ID_MemWrite & ID_VALID;
                ID_EX_RD1      <= ID_RD1;
                ID_EX_RD2      <= ID_RD2;
                ID_EX_IMM      <= ID_IMM;
                ID_EX_PC       <= ID_PC;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)                         STALL_CNT <= '0;
        else if (STALL && STALL_CNT != '1) STALL_CNT <= STALL_CNT + 1'b1;
    end

    // ID_EX holds a bubble in LU_BUBBLE, so a second hazard is impossible there.
    a_no_hz_in_bubble: assert property (@(posedge CLK) disable iff (!RSTn)
        (state_q == LU_BUBBLE) |-> !hz);

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32I core.
- Captures decoded ID-stage fields each cycle and presents them as ID_EX_* to the EX stage and to the forwarding unit.
- Holds the front end and inserts one bubble on a load-use hazard.
- Squashes its contents on a branch/jump flush.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
XLEN, 32, datapath width (operands, immediate, PC)
REG_AW, 5, register address width
CNT_W, 16, stall counter width

Ports:
CLK  in  1  core clock, rising edge
RSTn  in  1  asynchronous active-low reset
ID_VALID  in  1  IF/ID holds a real instruction
ID_OP  in  7  opcode of ID instruction
ID_RS1  in  REG_AW  source register 1 address
ID_RS2  in  REG_AW  source register 2 address
ID_RD  in  REG_AW  destination register address
ID_RS1_used  in  1  instruction reads rs1
ID_RS2_used  in  1  instruction reads rs2
ID_RegWrite  in  1  instruction writes rd
ID_MemRead  in  1  instruction is a load
ID_MemWrite  in  1  instruction is a store
ID_RD1  in  XLEN  register file read data 1
ID_RD2  in  XLEN  register file read data 2
ID_IMM  in  XLEN  decoded immediate
ID_PC  in  XLEN  PC of ID instruction
FLUSH  in  1  EX-stage redirect (taken branch/jump)
HOLD  in  1  global freeze (memory wait)
ID_EX_VALID  out  1  registered valid
ID_EX_OP  out  7  registered opcode
ID_EX_RS1  out  REG_AW  registered rs1
ID_EX_RS2  out  REG_AW  registered rs2
ID_EX_RD  out  REG_AW  registered rd
ID_EX_RS1_used  out  1  registered rs1-used
ID_EX_RS2_used  out  1  registered rs2-used
ID_EX_RegWrite  out  1  registered RegWrite, qualified
ID_EX_MemRead  out  1  registered MemRead, qualified
ID_EX_MemWrite  out  1  registered MemWrite, qualified
ID_EX_RD1  out  XLEN  registered operand 1
ID_EX_RD2  out  XLEN  registered operand 2
ID_EX_IMM  out  XLEN  registered immediate
ID_EX_PC  out  XLEN  registered PC
STALL  out  1  combinational; hold PC and IF/ID this cycle
STALL_CNT  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
Reset:
- RSTn low forces, asynchronously, all ID_EX_* outputs to 0, state to RUN, and STALL_CNT to 0.
- STALL is 0 while in reset.

Bubble definition:
- VALID, RegWrite, MemRead and MemWrite are 0.
- OP is 0010011 (addi x0, x0, 0 / NOP).
- RS*_used are 0.
- All other fields are 0.

Hazard (combinational), hz = ID_VALID & ID_EX_VALID & ID_EX_MemRead & (ID_EX_RD != 0) & ((ID_RS1_used & ID_RS1 == ID_EX_RD) | (ID_RS2_used & ID_RS2 == ID_EX_RD)).
- STALL = hz & ~FLUSH & ~HOLD.

Register update on the rising edge of CLK, by priority:
1. HOLD=1: all registers, state and STALL_CNT keep their value. HOLD overrides FLUSH for that cycle; the flush source keeps FLUSH asserted until HOLD drops.
2. FLUSH=1: load a bubble. The ID instruction is wrong-path and is discarded.
3. STALL=1: load a bubble. The ID instruction stays in IF/ID and is re-evaluated next cycle.
4. Otherwise: capture the ID_* fields.
   - ID_EX_VALID = ID_VALID.
   - RegWrite is written as ID_RegWrite & ID_VALID & (ID_RD != 0), so x0 is never a forwarding source.
   - MemRead and MemWrite are ANDed with ID_VALID.

State machine:
- RUN -> LU_BUBBLE when STALL=1 at the edge.
- LU_BUBBLE -> RUN unconditionally on the next non-HOLD edge.
- Assertion: hz must be 0 in LU_BUBBLE, because ID_EX now holds a bubble. A stall therefore lasts exactly 1 cycle per load-use pair.
- Back-to-back dependent loads (lw x1; lw x2,0(x1); add x3,x2,x0) produce two separate 1-cycle stalls.

STALL_CNT:
- Increments on every edge where STALL=1.
- Saturates at 2^CNT_W-1 and never wraps.
- Cleared only by reset.

Reset deasserted mid-stall resumes in RUN with a bubble in ID_EX.

Test Plan:
1. Load-use hazard:
   - Stimulus: lw x5 in ID_EX (MemRead=1, RD=5); ID has add with RS1=5, RS1_used=1.
   - Required: STALL=1 for exactly one cycle. The next cycle ID_EX is a bubble and state is LU_BUBBLE. The following cycle the add is captured. STALL_CNT goes 0->1.
2. Rs2 unused:
   - Stimulus: lw x5 in ID_EX; ID has addi with RS2 field=5, RS2_used=0.
   - Required: STALL=0 and the addi is captured immediately.
3. Writes to x0:
   - Stimulus: lw x0 in ID_EX and a dependent instruction reading x0 in ID.
   - Required: STALL=0.
   - Stimulus: capture add x0 in ID.
   - Required: ID_EX_RegWrite=0.
4. Flush during hazard:
   - Stimulus: FLUSH=1 while hz=1.
   - Required: STALL=0, ID_EX becomes a bubble, STALL_CNT unchanged.
5. HOLD:
   - Stimulus: HOLD=1 for 3 cycles with ID_EX holding PC=0x40 and FLUSH=1.
   - Required: ID_EX_PC stays 0x40 for all 3 cycles. The bubble is loaded on the first edge after HOLD drops.
6. Asynchronous reset:
   - Stimulus: RSTn pulsed low between clock edges while in LU_BUBBLE.
   - Required: all outputs 0 immediately, state RUN.
   - Stimulus: CNT_W=2 with 5 stalls.
   - Required: STALL_CNT saturates at 3.
